// File: rtl/ucode_sequencer.sv
// ucode_sequencer: microcode-driven control sequencer for SAP-family CPUs.
// Two fixed fetch words are followed by execute words read from a writable
// microcode RAM indexed by {opcode, step}. Each RAM entry can end the
// instruction early, or it can abort the instruction with a zero word when a
// selected flag is clear. A control word with the halt bit set freezes the
// sequencer until i_resume is pulsed.
// Optional feature: define UCODE_SEQUENCER_RETIRE_CNT_EN to add a 32-bit
// retired-instruction counter on o_retired.
//
// Handshake: i_resume is a level that is sampled on each rising edge. It has
// an effect only while o_halted is 1. There is no ready or acknowledge signal.
// The sequencer leaves the halted state on the first edge where i_resume is high.
module ucode_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CTRL_W   = 16,
  parameter int FLAG_W   = 2,
  parameter int HALT_BIT = 15,
  parameter logic [CTRL_W-1:0] FETCH0_WORD = 16'h4004,
  parameter logic [CTRL_W-1:0] FETCH1_WORD = 16'h1408,
  localparam int SEL_W   = (FLAG_W > 1) ? $clog2(FLAG_W) : 1,
  localparam int ADDR_W  = OPCODE_W + STEP_W,
  localparam int ENTRY_W = CTRL_W + 2 + SEL_W
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FLAG_W-1:0]   i_flags,
  input  logic                i_resume,
  input  logic                i_uc_we,
  input  logic [ADDR_W-1:0]   i_uc_addr,
  input  logic [ENTRY_W-1:0]  i_uc_wdata,
  output logic [CTRL_W-1:0]   o_control,
  output logic [STEP_W-1:0]   o_step,
  output logic                o_halted,
  output logic                o_instr_done
`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
  ,
  output logic [31:0]         o_retired
`endif
);

  localparam int RAM_DEPTH = 2 ** ADDR_W;

  // The microcode RAM has no reset, so its contents survive a reset.
  logic [ENTRY_W-1:0] ucode_mem [RAM_DEPTH];

  logic [CTRL_W-1:0] control_q, control_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;

  logic [ENTRY_W-1:0] entry;
  logic [CTRL_W-1:0]  e_ctrl;
  logic               e_last;
  logic               e_cond_en;
  logic [SEL_W-1:0]   e_sel;
  logic               flag_ok;
  logic               halted;

  assign halted = control_q[HALT_BIT];

  // The read is asynchronous. A write on the same edge is therefore seen
  // only from the next cycle, which gives read-before-write behaviour.
  assign entry     = ucode_mem[{i_opcode, step_q}];
  assign e_ctrl    = entry[CTRL_W-1:0];
  assign e_last    = entry[CTRL_W];
  assign e_cond_en = entry[CTRL_W+1];
  assign e_sel     = entry[ENTRY_W-1 -: SEL_W];

  // Look up the selected flag. A select value past the last flag reads as false.
  always_comb begin
    flag_ok = 1'b0;
    if (int'(e_sel) < FLAG_W) flag_ok = i_flags[e_sel];
  end

  // Microcode write port. Writes also land while the sequencer is halted.
  always_ff @(posedge i_clock) begin
    if (i_uc_we) ucode_mem[i_uc_addr] <= i_uc_wdata;
  end

  // Next-state logic: fetch steps, execute steps, halt hold and resume.
  always_comb begin
    control_d = control_q;
    step_d    = step_q;
    done_d    = done_q;
    if (halted) begin
      if (i_resume) begin
        control_d = '0;
        step_d    = '0;
        done_d    = 1'b0;
      end
    end else if (step_q == STEP_W'(0)) begin
      control_d = FETCH0_WORD;
      step_d    = STEP_W'(1);
      done_d    = 1'b0;
    end else if (step_q == STEP_W'(1)) begin
      control_d = FETCH1_WORD;
      step_d    = STEP_W'(2);
      done_d    = 1'b0;
    end else if (e_cond_en && !flag_ok) begin
      control_d = '0;
      step_d    = '0;
      done_d    = 1'b1;
    end else begin
      control_d = e_ctrl;
      if (e_last || (&step_q)) begin
        step_d = '0;
        done_d = 1'b1;
      end else begin
        step_d = step_q + STEP_W'(1);
        done_d = 1'b0;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      control_q <= '0;
      step_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      control_q <= control_d;
      step_q    <= step_d;
      done_q    <= done_d;
    end
  end

  assign o_control    = control_q;
  assign o_step       = step_q;
  assign o_halted     = halted;
  assign o_instr_done = done_q;

`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Count each instruction completion once. The counter freezes while halted.
  always_comb begin
    retired_d = retired_q;
    if (!halted && done_d) retired_d = retired_q + 32'd1;
  end

  // Retired-instruction counter register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) retired_q <= '0;
    else         retired_q <= retired_d;
  end

  assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Testbench for ucode_sequencer. The reference model expands each
// instruction into its expected list of control words from a shadow copy of
// the microcode. Every cycle of the DUT is then compared against that list.
module tb_ucode_sequencer;

  localparam int W = 21;  // {halted, step[2:0], done, ctrl[15:0]}

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_opcode = '0;
  logic [1:0]  i_flags = '0;
  logic        i_resume = 1'b0;
  logic        i_uc_we = 1'b0;
  logic [6:0]  i_uc_addr = '0;
  logic [18:0] i_uc_wdata = '0;
  logic [15:0] o_control;
  logic [2:0]  o_step;
  logic        o_halted;
  logic        o_instr_done;
`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
  logic [31:0] o_retired;
`endif

  ucode_sequencer dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_opcode     (i_opcode),
    .i_flags      (i_flags),
    .i_resume     (i_resume),
    .i_uc_we      (i_uc_we),
    .i_uc_addr    (i_uc_addr),
    .i_uc_wdata   (i_uc_wdata),
    .o_control    (o_control),
    .o_step       (o_step),
    .o_halted     (o_halted),
    .o_instr_done (o_instr_done)
`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
    ,
    .o_retired    (o_retired)
`endif
  );

  // Clock and bookkeeping.
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Shadow microcode, written alongside the DUT RAM. Power-up content is 0.
  logic [15:0] m_ctrl [128];
  bit          m_last [128];
  bit          m_cen  [128];
  int          m_sel  [128];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  function automatic logic [W-1:0] mk(input logic [15:0] ctrl, input bit done, input int step);
    logic [2:0] s;
    s = 3'(step);
    return {ctrl[15], s, done, ctrl};
  endfunction

  // Reference model: the full word sequence for one instruction.
  task automatic build_exp(input int op, input logic [1:0] flags);
    exp_q.delete();
    exp_q.push_back(mk(16'h4004, 1'b0, 1));
    exp_q.push_back(mk(16'h1408, 1'b0, 2));
    for (int s = 2; s < 8; s++) begin
      int  idx;
      bit  fl;
      bit  d;
      idx = op * 8 + s;
      fl  = (m_sel[idx] < 2) ? flags[m_sel[idx]] : 1'b0;
      if (m_cen[idx] && !fl) begin
        exp_q.push_back(mk(16'h0000, 1'b1, 0));
        break;
      end
      d = m_last[idx] || (s == 7);
      exp_q.push_back(mk(m_ctrl[idx], d, d ? 0 : s + 1));
      if (d) break;
    end
  endtask

  // Driver tasks.
  task automatic uc_write(input int op, input int st, input logic [15:0] ctrl,
                          input bit last, input bit cen, input int sel);
    int idx;
    idx = op * 8 + st;
    i_uc_we    = 1'b1;
    i_uc_addr  = 7'(idx);
    i_uc_wdata = {1'(sel), cen, last, ctrl};
    @(posedge i_clock); #1;
    i_uc_we = 1'b0;
    m_ctrl[idx] = ctrl; m_last[idx] = last; m_cen[idx] = cen; m_sel[idx] = sel;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clock); #1;
      obs_q.push_back({o_halted, o_step, o_instr_done, o_control});
    end
  endtask

  task automatic run_instr(input int op, input logic [1:0] flags);
    i_opcode = 4'(op);
    i_flags  = flags;
    build_exp(op, flags);
    obs_q.delete();
    run_cycles(exp_q.size());
  endtask

  task automatic release_reset();
    @(posedge i_clock); #1;
    i_reset = 1'b0;
  endtask

  // Scenario tasks.
  task automatic test_reset();
    #3;
    n_checks++; if (o_control !== 16'h0) begin n_fail++; $display("FAIL reset_control got %h want 0000", o_control); end
    n_checks++; if (o_step !== 3'd0) begin n_fail++; $display("FAIL reset_step got %0d want 0", o_step); end
    n_checks++; if (o_instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_instr_done); end
    n_checks++; if (o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", o_halted); end
  endtask

  task automatic test_blank_opcode();
    release_reset();
    run_instr(0, 2'b00);
    n_checks++; if (exp_q.size() != 8) begin n_fail++; $display("FAIL blank_len got %0d want 8", exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL blank_word%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    @(posedge i_clock); #1;
    n_checks++; if (o_control !== 16'h4004) begin n_fail++; $display("FAIL blank_refetch got %h want 4004", o_control); end
  endtask

  task automatic test_lda();
    i_reset = 1'b1;
    uc_write(1, 2, 16'h4800, 1'b0, 1'b0, 0);
    uc_write(1, 3, 16'h1200, 1'b1, 1'b0, 0);
    uc_write(8, 2, 16'h0802, 1'b1, 1'b1, 1);
    uc_write(15, 2, 16'h8000, 1'b1, 1'b0, 0);
    release_reset();
    run_instr(1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lda_word%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    @(posedge i_clock); #1;
    n_checks++; if (o_control !== 16'h4004) begin n_fail++; $display("FAIL lda_refetch got %h want 4004", o_control); end
    @(posedge i_clock); #1;  // finish the fetch so the next instruction starts at step 0
    i_opcode = 4'd0;
    for (int i = 0; i < 6; i++) begin @(posedge i_clock); #1; end
  endtask

  task automatic test_cond();
    i_reset = 1'b1;
    release_reset();
    run_instr(8, 2'b10);
    n_checks++; if (obs_q[2] !== mk(16'h0802, 1'b1, 0)) begin n_fail++; $display("FAIL cond_taken got %h want %h", obs_q[2], mk(16'h0802, 1'b1, 0)); end
    run_instr(8, 2'b00);
    n_checks++; if (obs_q[2] !== mk(16'h0000, 1'b1, 0)) begin n_fail++; $display("FAIL cond_abort got %h want %h", obs_q[2], mk(16'h0000, 1'b1, 0)); end
    n_checks++; if (obs_q[2] !== exp_q[2]) begin n_fail++; $display("FAIL cond_model got %h want %h", obs_q[2], exp_q[2]); end
  endtask

  task automatic test_halt();
    logic [31:0] r0;
    r0 = '0;
    i_reset = 1'b1;
    release_reset();
`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
    r0 = o_retired;
`endif
    run_instr(15, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL halt_word%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    i_opcode = 4'd1;
    i_flags  = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clock); #1;
      n_checks++;
      if ({o_halted, o_step, o_instr_done, o_control} !== mk(16'h8000, 1'b1, 0)) begin
        n_fail++; $display("FAIL halt_hold%0d got %h want %h", i, {o_halted, o_step, o_instr_done, o_control}, mk(16'h8000, 1'b1, 0));
      end
    end
`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
    n_checks++; if (o_retired !== r0 + 32'd1) begin n_fail++; $display("FAIL halt_retired got %0d want %0d", o_retired, r0 + 32'd1); end
`endif
    i_resume = 1'b1;
    @(posedge i_clock); #1;
    i_resume = 1'b0;
    n_checks++;
    if ({o_halted, o_step, o_instr_done, o_control} !== mk(16'h0000, 1'b0, 0)) begin
      n_fail++; $display("FAIL resume_word got %h want %h", {o_halted, o_step, o_instr_done, o_control}, mk(16'h0000, 1'b0, 0));
    end
    @(posedge i_clock); #1;
    n_checks++; if (o_control !== 16'h4004) begin n_fail++; $display("FAIL resume_fetch got %h want 4004", o_control); end
`ifdef UCODE_SEQUENCER_RETIRE_CNT_EN
    n_checks++; if (o_retired !== r0 + 32'd1) begin n_fail++; $display("FAIL resume_retired got %0d want %0d", o_retired, r0 + 32'd1); end
`endif
  endtask

  task automatic test_async_reset();
    i_reset = 1'b1;
    release_reset();
    i_opcode = 4'd1;
    obs_q.delete();
    run_cycles(3);
    n_checks++; if (o_step !== 3'd3) begin n_fail++; $display("FAIL areset_pre_step got %0d want 3", o_step); end
    i_reset = 1'b1;
    #2;
    n_checks++; if (o_control !== 16'h0) begin n_fail++; $display("FAIL areset_control got %h want 0000", o_control); end
    n_checks++; if (o_step !== 3'd0) begin n_fail++; $display("FAIL areset_step got %0d want 0", o_step); end
    release_reset();
    run_instr(1, 2'b00);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL areset_replay%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_read_before_write();
    i_reset = 1'b1;
    release_reset();
    i_opcode = 4'd1;
    i_flags  = 2'b00;
    run_cycles(3);
    i_uc_we    = 1'b1;
    i_uc_addr  = 7'(1 * 8 + 3);
    i_uc_wdata = {1'b0, 1'b0, 1'b1, 16'h00FF};
    @(posedge i_clock); #1;
    i_uc_we = 1'b0;
    n_checks++; if (o_control !== 16'h1200) begin n_fail++; $display("FAIL rbw_old got %h want 1200", o_control); end
    n_checks++; if (o_instr_done !== 1'b1) begin n_fail++; $display("FAIL rbw_done got %b want 1", o_instr_done); end
    m_ctrl[11] = 16'h00FF; m_last[11] = 1'b1; m_cen[11] = 1'b0; m_sel[11] = 0;
    run_instr(1, 2'b00);
    n_checks++; if (obs_q[3] !== mk(16'h00FF, 1'b1, 0)) begin n_fail++; $display("FAIL rbw_new got %h want %h", obs_q[3], mk(16'h00FF, 1'b1, 0)); end
  endtask

  task automatic test_random();
    i_reset = 1'b1;
    for (int op = 2; op < 8; op++) begin
      for (int st = 2; st < 8; st++) begin
        logic [15:0] c;
        c = 16'($urandom()) & 16'h7FFF;
        uc_write(op, st, c, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      end
    end
    release_reset();
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 14);
      run_instr(op, 2'($urandom_range(0, 3)));
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_i%0d_op%0d_w%0d got %h want %h", n, op, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      m_ctrl[i] = '0; m_last[i] = 1'b0; m_cen[i] = 1'b0; m_sel[i] = 0;
    end
    test_reset();
    test_blank_opcode();
    test_lda();
    test_cond();
    test_halt();
    test_async_reset();
    test_read_before_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
Parametrised, microcode-driven control sequencer for the SAP-family CPUs. It succeeds the hard-wired controller. Fetch words are parameters. Execute steps come from a writable microcode RAM indexed by {opcode, step}, each entry carrying an end-of-instruction flag and an optional flag-qualified condition. It sits between the instruction/flags registers and every bus-control input of the datapath, and adds halt/resume handshaking.

Parameters:
OPCODE_W, 4, opcode width
STEP_W, 3, step counter width; MAX_STEPS = 2**STEP_W
CTRL_W, 16, control word width
FLAG_W, 2, number of flag inputs; SEL_W = max(1, clog2(FLAG_W))
HALT_BIT, 15, index of the halt bit within the control word
FETCH0_WORD, 16'h4004, control word for step 0 (PC out, MAR in)
FETCH1_WORD, 16'h1408, control word for step 1 (RAM out, IR in, PC inc)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_opcode  in  OPCODE_W  opcode from the instruction register
i_flags  in  FLAG_W  flag register outputs (bit0 carry, bit1 zero by default)
i_resume  in  1  leave the halted state
i_uc_we  in  1  microcode write enable
i_uc_addr  in  OPCODE_W+STEP_W  microcode write address {opcode, step}
i_uc_wdata  in  CTRL_W+2+SEL_W  entry: [CTRL_W-1:0] ctrl, [CTRL_W] last, [CTRL_W+1] cond_en, [top SEL_W bits] cond_sel
o_control  out  CTRL_W  registered control word
o_step  out  STEP_W  step that the next clock will execute
o_halted  out  1  equals o_control[HALT_BIT]
o_instr_done  out  1  high while o_control holds an instruction's final word

Behaviour:
- Reset (async): o_control=0, step=0, o_instr_done=0. o_halted=0 follows. Microcode RAM is not cleared and keeps its contents through reset.
- RAM: 2**(OPCODE_W+STEP_W) entries. Entries at step 0/1 exist but are never read. Synchronous write on i_uc_we. Same-cycle write to the entry being read: the read returns the old data (read-before-write). RAM power-up content is 0.
- Each rising edge when not halted, all outputs are registered:
  - step 0: o_control<=FETCH0_WORD, step<=1, done<=0.
  - step 1: o_control<=FETCH1_WORD, step<=2, done<=0.
  - step>=2: e=ram[{i_opcode,step}].
    - If e.cond_en and i_flags[e.cond_sel]==0: o_control<=0, step<=0, done<=1.
    - Else o_control<=e.ctrl. If e.last or step==MAX_STEPS-1, then step<=0 and done<=1. Otherwise step<=step+1 and done<=0.
- cond_sel >= FLAG_W is treated as flag false.
- Instruction length: 3..MAX_STEPS cycles. Step wrap is forced at MAX_STEPS-1 even if last=0.
- Halt: while o_control[HALT_BIT]=1, step, o_control and done freeze. i_opcode, i_flags and microcode writes are ignored for sequencing. Microcode writes still land in RAM.
- i_resume while halted: next edge sets o_control<=0, step<=0, done<=0. The following edge fetches. i_resume while not halted is ignored.
- i_opcode is sampled at every execute step, not latched. It must stay stable from step 2 to the end of the instruction.

Optional Feature:
Macro UCODE_SEQUENCER_RETIRE_CNT_EN.
- Defined: adds port o_retired (out, 32 bits). It resets to 0 and increments on each edge where done is registered as 1. It wraps at 2**32, holds while halted, and counts the HLT instruction once.
- Undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
1. Reset, RAM untouched, opcode 0 → o_control 4004, 1408, then 0000 for 6 cycles (steps 2..7). o_instr_done=1 only on the step-7 word. o_step returns to 0, then 4004 repeats.
2. Write {1,2}=ctrl 4800 last 0 and {1,3}=ctrl 1200 last 1; opcode 1 → 4004, 1408, 4800, 1200(done=1), 4004.
3. Write {8,2}=ctrl 0802 last 1 cond_en 1 cond_sel 1; opcode 8:
   - i_flags=2'b10 → third word 0802, done=1.
   - i_flags=2'b00 → third word 0000, done=1, step→0.
4. Write {15,2}=ctrl 8000 last 1; opcode 15 → o_halted=1 and o_control=8000 held for 10 clocks. Pulse i_resume → next word 0000, then 4004. With the macro enabled, o_retired increments by exactly 1 for the HLT.
5. Assert i_reset mid-LDA at step 3 → o_control=0 and o_step=0 without a clock edge. Replay LDA after release → 4800/1200 unchanged (RAM preserved).
6. During opcode 1 step 3, write {1,3}=ctrl 00FF in the same cycle → that cycle drives 1200 (old data). The next LDA drives 00FF.
